// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data/address words, fetch FSM states and reset PC.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WORD_W-1:0] addr_t;

  // Fetch stage control states.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    STALLED = 2'd1,
    HALTED  = 2'd2
  } fetch_state_t;

  localparam word_t PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with load / increment / hold control.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   load, load_addr - load a redirect target (takes priority over inc)
//   inc             - advance by STEP bytes, wrapping modulo 2^32
//   pc              - current program counter
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter addr_t       INIT = PC_RESET_DEFAULT,
  parameter int unsigned STEP = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  inc,
  input  addr_t load_addr,
  output addr_t pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= INIT;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + WORD_W'(STEP);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache requests, feeds IF/ID.
// A one-entry skid buffer holds a fetched word while the hazard unit stalls.
// Ports:
//   CLK, RST                       - clock, synchronous active-high reset
//   stall                          - hazard unit holds IF/ID
//   redirect_valid, redirect_addr  - taken branch/jump from downstream
//   halt                           - halt instruction reached WB
//   ihit, imemload                 - icache response for imemaddr
//   imemREN, imemaddr              - icache request and address (= pc)
//   ifid_WEN, ifid_flush           - IF/ID write enable and bubble insert
//   instruction_out, next_address_out - IF/ID payload
//   fetch_count                    - instructions delivered to IF/ID
//   halted                         - stage is halted
// IF/ID controls and payload are combinational so IF/ID latches them on the
// same edge that advances the PC.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter addr_t       PC_INIT = PC_RESET_DEFAULT,
  parameter int unsigned PC_STEP = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  stall,
  input  logic  redirect_valid,
  input  addr_t redirect_addr,
  input  logic  halt,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output addr_t imemaddr,
  output logic  ifid_WEN,
  output logic  ifid_flush,
  output word_t instruction_out,
  output addr_t next_address_out,
  output word_t fetch_count,
  output logic  halted
);

  fetch_state_t state;
  word_t        buf_instr;
  addr_t        buf_next;
  addr_t        pc;
  addr_t        pc_plus;
  logic         pc_load;
  logic         pc_inc;

  assign pc_plus  = pc + WORD_W'(PC_STEP);
  assign imemaddr = pc;

  pc_reg #(
    .INIT (PC_INIT),
    .STEP (PC_STEP)
  ) u_pc_reg (
    .clk       (CLK),
    .rst       (RST),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (redirect_addr & ~32'h3),
    .pc        (pc)
  );

  // PC control and IF/ID outputs; priority RST > halt > redirect > ihit/stall.
  always_comb begin
    pc_load          = 1'b0;
    pc_inc           = 1'b0;
    imemREN          = 1'b0;
    ifid_WEN         = 1'b0;
    ifid_flush       = 1'b0;
    halted           = 1'b0;
    instruction_out  = '0;
    next_address_out = '0;
    if (!RST) begin
      halted  = (state == HALTED);
      imemREN = (state == FETCH);
      if (state == STALLED) begin
        instruction_out  = buf_instr;
        next_address_out = buf_next;
      end else begin
        instruction_out  = imemload;
        next_address_out = pc_plus;
      end
      if (state != HALTED) begin
        if (halt) begin
          ifid_flush = 1'b1;
        end else if (redirect_valid) begin
          ifid_flush = 1'b1;
          pc_load    = 1'b1;
        end else if (state == FETCH) begin
          pc_inc   = ihit;
          ifid_WEN = ihit && !stall;
        end else begin
          ifid_WEN = !stall;
        end
      end
    end
  end

  // FSM, skid buffer and delivered-instruction counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= FETCH;
      buf_instr   <= '0;
      buf_next    <= '0;
      fetch_count <= '0;
    end else if (halt) begin
      state <= HALTED;
    end else begin
      case (state)
        HALTED: state <= HALTED;
        FETCH: begin
          if (redirect_valid) begin
            buf_instr <= '0;
            buf_next  <= '0;
          end else if (ihit && stall) begin
            buf_instr <= imemload;
            buf_next  <= pc_plus;
            state     <= STALLED;
          end else if (ihit) begin
            fetch_count <= fetch_count + 32'd1;
          end
        end
        STALLED: begin
          if (redirect_valid) begin
            buf_instr <= '0;
            buf_next  <= '0;
            state     <= FETCH;
          end else if (!stall) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; a second instance with
// PC_INIT=32'hFFFF_FFFC shares the stimulus to exercise PC wrap.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;

  logic        imemREN, ifid_WEN, ifid_flush, halted;
  logic [31:0] imemaddr, instruction_out, next_address_out, fetch_count;

  logic        w_imemREN, w_ifid_WEN, w_ifid_flush, w_halted;
  logic [31:0] w_imemaddr, w_instruction_out, w_next_address_out, w_fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .halt(halt), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .ifid_WEN(ifid_WEN),
    .ifid_flush(ifid_flush), .instruction_out(instruction_out),
    .next_address_out(next_address_out), .fetch_count(fetch_count), .halted(halted)
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .CLK(CLK), .RST(RST), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .halt(halt), .ihit(ihit), .imemload(imemload),
    .imemREN(w_imemREN), .imemaddr(w_imemaddr), .ifid_WEN(w_ifid_WEN),
    .ifid_flush(w_ifid_flush), .instruction_out(w_instruction_out),
    .next_address_out(w_next_address_out), .fetch_count(w_fetch_count), .halted(w_halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let inputs change mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #2;
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    halt = 1'b0; ihit = 1'b1; imemload = 32'hDEAD_BEEF;
    tick(); tick();
    settle();
    // Reset: everything quiet even with ihit high
    chk("rst_ren", 32'(imemREN), 32'd0);
    chk("rst_wen", 32'(ifid_WEN), 32'd0);
    chk("rst_flush", 32'(ifid_flush), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_instr", instruction_out, 32'd0);
    chk("rst_next", next_address_out, 32'd0);
    chk("rst_pc", imemaddr, 32'h0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_wrap_pc", w_imemaddr, 32'hFFFF_FFFC);

    // Sequential fetch 0,4,8
    tick(); RST = 1'b0; imemload = 32'h1000_0000; settle();
    chk("seq0_addr", imemaddr, 32'h0);
    chk("seq0_ren", 32'(imemREN), 32'd1);
    chk("seq0_wen", 32'(ifid_WEN), 32'd1);
    chk("seq0_instr", instruction_out, 32'h1000_0000);
    chk("seq0_next", next_address_out, 32'h4);
    chk("wrap_next", w_next_address_out, 32'h0);
    chk("wrap_wen", 32'(w_ifid_WEN), 32'd1);
    tick(); imemload = 32'h1000_0004; settle();
    chk("seq1_addr", imemaddr, 32'h4);
    chk("seq1_next", next_address_out, 32'h8);
    chk("wrap_pc", w_imemaddr, 32'h0);
    chk("wrap_count", w_fetch_count, 32'd1);
    tick(); imemload = 32'h1000_0008; settle();
    chk("seq2_addr", imemaddr, 32'h8);
    chk("seq2_wen", 32'(ifid_WEN), 32'd1);
    chk("seq2_next", next_address_out, 32'hC);
    tick(); settle();
    chk("seq_count", fetch_count, 32'd3);
    chk("seq_pc", imemaddr, 32'hC);

    // Stall with a hit at pc=0xC: word goes to skid buffer
    ihit = 1'b1; stall = 1'b1; imemload = 32'hAAAA_000C; settle();
    chk("stl_cap_wen", 32'(ifid_WEN), 32'd0);
    chk("stl_cap_ren", 32'(imemREN), 32'd1);
    tick(); ihit = 1'b0; imemload = 32'h5555_5555; settle();
    chk("stl1_ren", 32'(imemREN), 32'd0);
    chk("stl1_wen", 32'(ifid_WEN), 32'd0);
    chk("stl1_pc", imemaddr, 32'h10);
    tick(); settle();
    chk("stl2_ren", 32'(imemREN), 32'd0);
    chk("stl2_count", fetch_count, 32'd3);
    tick(); stall = 1'b0; settle();
    chk("rel_wen", 32'(ifid_WEN), 32'd1);
    chk("rel_instr", instruction_out, 32'hAAAA_000C);
    chk("rel_next", next_address_out, 32'h10);
    tick(); settle();
    chk("post_rel_ren", 32'(imemREN), 32'd1);
    chk("post_rel_addr", imemaddr, 32'h10);
    chk("post_rel_count", fetch_count, 32'd4);
    chk("post_rel_nodup", 32'(ifid_WEN), 32'd0);

    // Miss at 0x10, redirect on second miss cycle (low bits ignored)
    chk("miss1_flush", 32'(ifid_flush), 32'd0);
    tick(); settle();
    chk("miss1_hold", imemaddr, 32'h10);
    redirect_valid = 1'b1; redirect_addr = 32'h43; settle();
    chk("redir_flush", 32'(ifid_flush), 32'd1);
    chk("redir_wen", 32'(ifid_WEN), 32'd0);
    tick(); redirect_valid = 1'b0; settle();
    chk("redir_pc", imemaddr, 32'h40);
    chk("redir_count", fetch_count, 32'd4);
    chk("redir_flush_off", 32'(ifid_flush), 32'd0);
    tick(); settle();
    chk("miss4_pc", imemaddr, 32'h40);

    // Redirect while STALLED with stall high
    ihit = 1'b1; stall = 1'b1; imemload = 32'hBBBB_0040;
    tick(); ihit = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h80; settle();
    chk("sredir_flush", 32'(ifid_flush), 32'd1);
    chk("sredir_wen", 32'(ifid_WEN), 32'd0);
    tick(); redirect_valid = 1'b0; stall = 1'b0; settle();
    chk("sredir_pc", imemaddr, 32'h80);
    chk("sredir_ren", 32'(imemREN), 32'd1);
    chk("sredir_drop", 32'(ifid_WEN), 32'd0);
    chk("sredir_count", fetch_count, 32'd4);

    // Redirect drops a same-cycle hit
    ihit = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h20; settle();
    chk("hredir_wen", 32'(ifid_WEN), 32'd0);
    chk("hredir_flush", 32'(ifid_flush), 32'd1);
    tick(); redirect_valid = 1'b0; settle();
    chk("hredir_pc", imemaddr, 32'h20);
    chk("hredir_count", fetch_count, 32'd4);

    // Halt at 0x20
    halt = 1'b1; settle();
    chk("halt_flush", 32'(ifid_flush), 32'd1);
    chk("halt_wen", 32'(ifid_WEN), 32'd0);
    tick(); halt = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'h100; settle();
    chk("halted", 32'(halted), 32'd1);
    chk("halted_ren", 32'(imemREN), 32'd0);
    chk("halted_wen", 32'(ifid_WEN), 32'd0);
    chk("halted_flush", 32'(ifid_flush), 32'd0);
    chk("halted_pc", imemaddr, 32'h20);
    tick(); redirect_valid = 1'b0; settle();
    chk("halted_frozen", imemaddr, 32'h20);
    chk("halted_stay", 32'(halted), 32'd1);
    chk("halted_count", fetch_count, 32'd4);

    // Reset out of HALTED
    RST = 1'b1; settle();
    chk("hrst_halted", 32'(halted), 32'd0);
    tick(); RST = 1'b0; ihit = 1'b0; settle();
    chk("hrst_pc", imemaddr, 32'h0);
    chk("hrst_count", fetch_count, 32'd0);
    chk("hrst_halted2", 32'(halted), 32'd0);
    chk("hrst_ren", 32'(imemREN), 32'd1);
    chk("hrst_wrap_pc", w_imemaddr, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
